playback_scheduler: RTL

- Single-clock replacement for the divided play clock plus beat-counter pair.
- Generates the beat index that drives the music ROM from the 100 MHz `clk` using a programmable tempo divider. No derived clocks.
- Sequences the play, pause, loop-hold and reverse modes from pre-debounced, one-pulsed user controls.
- Sits between the button/keyboard front end and the music module; its `ibeat` feeds the tone lookup and the seven-segment display.

---
 rtl/playback_scheduler_pkg.sv | 24 ++
 rtl/playback_scheduler_tempo_divider.sv | 36 +++
 rtl/playback_scheduler.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/playback_scheduler_pkg.sv
// Shared state encoding, tempo and loop-window limits for the playback scheduler.
package playback_pkg;

  typedef enum logic [1:0] {
    STOP  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2,
    LOOP  = 2'd3
  } state_t;

  localparam logic [2:0] SPEED_MIN     = 3'd0;
  localparam logic [2:0] SPEED_MAX     = 3'd4;
  localparam logic [2:0] SPEED_DEFAULT = 3'd2;

  localparam logic [2:0] LOOP_W_MIN = 3'd2;
  localparam logic [2:0] LOOP_W_MAX = 3'd6;

  function automatic logic [2:0] clamp_loop_width(input logic [2:0] w);
    if (w < LOOP_W_MIN) return LOOP_W_MIN;
    if (w > LOOP_W_MAX) return LOOP_W_MAX;
    return w;
  endfunction

endpackage

// File: rtl/playback_scheduler_tempo_divider.sv
// Programmable beat-period counter: emits a terminal-count pulse every
// (4*BASE_DIV >> speed_level) enabled cycles; holds its count while disabled.
module tempo_divider #(
  parameter int BASE_DIV = 6250000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       clear,
  input  logic [2:0] speed_level,
  output logic       tc
);

  localparam int CNT_W = $clog2(4 * BASE_DIV + 1);
  localparam logic [CNT_W-1:0] DIV_MAX = CNT_W'(4 * BASE_DIV);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] div;
  logic [CNT_W-1:0] div_m1;

  assign div    = DIV_MAX >> speed_level;
  assign div_m1 = div - CNT_W'(1);
  // A tempo change restarts the beat, so it suppresses a coincident terminal count.
  assign tc     = enable && !clear && (count_reg == div_m1);

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      count_reg <= '0;
    end else if (tc) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/playback_scheduler.sv
// Beat sequencer for the music ROM: play/pause/loop/reverse FSM on a single clock.
// Optional build macro PLAYBACK_SCHED_STEP_EN: speed pulses single-step ibeat while paused.
module playback_scheduler
  import playback_pkg::*;
#(
  parameter int LEN      = 64,
  parameter int BASE_DIV = 6250000,
  parameter int BEAT_W   = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              play_1p,
  input  logic              speed_up_1p,
  input  logic              speed_down_1p,
  input  logic              loop_hold,
  input  logic [2:0]        loop_width,
  input  logic              reverse,
  output logic [BEAT_W-1:0] ibeat,
  output logic              beat_tick,
  output logic              playing,
  output logic [2:0]        speed_level,
  output logic [BEAT_W-1:0] loop_start
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LEN - 1);
  localparam logic [BEAT_W:0]   LEN_X     = (BEAT_W + 1)'(LEN);
  localparam logic [BEAT_W:0]   ONE_X     = (BEAT_W + 1)'(1);

  state_t            state_reg;
  logic [BEAT_W-1:0] ibeat_reg, ibeat_next;
  logic [BEAT_W-1:0] loop_start_reg;
  logic [2:0]        level_reg, level_next;
  logic              beat_tick_reg, tick_next;
  logic              playing_reg;

  logic              tc;
  logic              running;
  logic              level_change;
  logic              step_mode;
  logic              up_only, down_only;
  logic [2:0]        win_w;
  logic [BEAT_W:0]   win_w_x, offset, win_end_x;
  logic [BEAT_W-1:0] win_end, beat_fwd, beat_rev, beat_adv;

  function automatic logic [BEAT_W-1:0] wrap_inc(input logic [BEAT_W-1:0] b);
    return (b == LAST_BEAT) ? '0 : b + BEAT_W'(1);
  endfunction

  function automatic logic [BEAT_W-1:0] wrap_dec(input logic [BEAT_W-1:0] b);
    return (b == '0) ? LAST_BEAT : b - BEAT_W'(1);
  endfunction

  assign running   = (state_reg == PLAY) || (state_reg == LOOP);
  assign up_only   = speed_up_1p && !speed_down_1p;
  assign down_only = speed_down_1p && !speed_up_1p;

`ifdef PLAYBACK_SCHED_STEP_EN
  assign step_mode = (state_reg == PAUSE);
`else
  assign step_mode = 1'b0;
`endif

  tempo_divider #(
    .BASE_DIV(BASE_DIV)
  ) u_tempo (
    .clk        (clk),
    .rst        (rst),
    .enable     (running),
    .clear      (level_change),
    .speed_level(level_reg),
    .tc         (tc)
  );

  // Speed level: both pulses together cancel; saturating at either end.
  always_comb begin
    level_next = level_reg;
    if (!step_mode) begin
      if (up_only && (level_reg < SPEED_MAX)) begin
        level_next = level_reg + 3'd1;
      end else if (down_only && (level_reg > SPEED_MIN)) begin
        level_next = level_reg - 3'd1;
      end
    end
    level_change = (level_next != level_reg);
  end

  // Loop window arithmetic, all modulo LEN: offset of ibeat inside the window and its last beat.
  always_comb begin
    win_w   = clamp_loop_width(loop_width);
    win_w_x = (BEAT_W + 1)'(win_w);
    if (ibeat_reg >= loop_start_reg) begin
      offset = {1'b0, ibeat_reg} - {1'b0, loop_start_reg};
    end else begin
      offset = {1'b0, ibeat_reg} + LEN_X - {1'b0, loop_start_reg};
    end
    win_end_x = {1'b0, loop_start_reg} + win_w_x - ONE_X;
    win_end   = (win_end_x >= LEN_X) ? BEAT_W'(win_end_x - LEN_X) : BEAT_W'(win_end_x);
  end

  always_comb begin
    beat_fwd = wrap_inc(ibeat_reg);
    beat_rev = wrap_dec(ibeat_reg);
    beat_adv = reverse ? beat_rev : beat_fwd;
    if (state_reg == LOOP) begin
      if (!reverse) begin
        beat_adv = (offset >= (win_w_x - ONE_X)) ? loop_start_reg : beat_fwd;
      end else if (offset >= win_w_x) begin
        beat_adv = loop_start_reg;
      end else if (offset == '0) begin
        beat_adv = win_end;
      end else begin
        beat_adv = beat_rev;
      end
    end
  end

  always_comb begin
    ibeat_next = ibeat_reg;
    tick_next  = 1'b0;
    if (tc) begin
      ibeat_next = beat_adv;
      tick_next  = 1'b1;
    end else if (step_mode && up_only) begin
      ibeat_next = beat_fwd;
      tick_next  = 1'b1;
    end else if (step_mode && down_only) begin
      ibeat_next = beat_rev;
      tick_next  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg      <= STOP;
      playing_reg    <= 1'b0;
      loop_start_reg <= '0;
      ibeat_reg      <= '0;
      beat_tick_reg  <= 1'b0;
      level_reg      <= SPEED_DEFAULT;
    end else begin
      ibeat_reg     <= ibeat_next;
      beat_tick_reg <= tick_next;
      level_reg     <= level_next;
      // play_1p outranks loop_hold in every state.
      case (state_reg)
        STOP: begin
          if (play_1p) begin
            state_reg   <= PLAY;
            playing_reg <= 1'b1;
          end
        end
        PLAY: begin
          if (play_1p) begin
            state_reg   <= PAUSE;
            playing_reg <= 1'b0;
          end else if (loop_hold) begin
            state_reg      <= LOOP;
            loop_start_reg <= ibeat_reg;
          end
        end
        PAUSE: begin
          if (play_1p) begin
            state_reg   <= PLAY;
            playing_reg <= 1'b1;
          end
        end
        LOOP: begin
          if (play_1p) begin
            state_reg   <= PAUSE;
            playing_reg <= 1'b0;
          end else if (!loop_hold) begin
            state_reg <= PLAY;
          end
        end
        default: begin
          state_reg   <= STOP;
          playing_reg <= 1'b0;
        end
      endcase
    end
  end

  assign ibeat       = ibeat_reg;
  assign beat_tick   = beat_tick_reg;
  assign playing     = playing_reg;
  assign speed_level = level_reg;
  assign loop_start  = loop_start_reg;

endmodule
